// File: rtl/cache_tag_store_pkg.sv
// Shared types and defaults for the direct-mapped cache tag store.
// Define CACHE_TAG_DIRTY_EN to add a dirty bit to every entry.
package cache_tag_store_pkg;

    localparam int CACHE_IDX_BITS = 11;
    localparam int CACHE_TAG_BITS = 8;

`ifdef CACHE_TAG_DIRTY_EN
    localparam int DIRTY_EN = 1;
`else
    localparam int DIRTY_EN = 0;
`endif

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Entry layout: tag at [TAG_BITS-1:0], valid at TAG_BITS, dirty (optional) at TAG_BITS+1.
    function automatic int entry_width(input int tag_bits);
        return tag_bits + 1 + DIRTY_EN;
    endfunction

endpackage

// File: rtl/cache_tag_store_tag_ram_sp.sv
// Inferred tag RAM: one write port, one registered read port, no reset on storage.
module tag_ram_sp #(
    parameter int WIDTH     = 9,
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    // Read data only moves on a read enable, so it holds between lookups.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cache_tag_store.sv
// Direct-mapped cache tag store: registered lookup with hit compare, update port, invalidate-all sweep.
// Optional dirty bit per entry when CACHE_TAG_DIRTY_EN is defined.
module cache_tag_store
    import cache_tag_store_pkg::*;
#(
    parameter int IDX_BITS = CACHE_IDX_BITS,
    parameter int TAG_BITS = CACHE_TAG_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                lookup_valid,
    output logic                lookup_ready,
    input  logic [IDX_BITS-1:0] lookup_idx,
    input  logic [TAG_BITS-1:0] lookup_tag,
    output logic                rsp_valid,
    output logic                rsp_hit,
    output logic                rsp_dirty,
    output logic [TAG_BITS-1:0] rsp_tag,
    input  logic                upd_wren,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic [TAG_BITS-1:0] upd_tag,
    input  logic                upd_valid,
    input  logic                upd_dirty,
    input  logic                flush_req,
    output logic                busy,
    output logic                flush_done,
    output state_t              fsm_state
);

    localparam int ENTRY_W   = entry_width(TAG_BITS);
    localparam int VALID_BIT = TAG_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

    // Handshake: a lookup is taken on any rising edge where lookup_valid && lookup_ready;
    // its rsp_* appear with rsp_valid on the following cycle and hold until the next response.
    state_t              state, next_state;
    logic [IDX_BITS-1:0] cnt, next_cnt;
    logic                next_done;
    logic                accept, upd_ok, bypass;
    logic [ENTRY_W-1:0]  upd_entry, rd_entry, stored, byp_entry_q;
    logic                byp_en_q;
    logic [TAG_BITS-1:0] tag_q;
    logic                ram_we;
    logic [IDX_BITS-1:0] ram_waddr;
    logic [ENTRY_W-1:0]  ram_wdata;

    assign busy         = (state == ST_FLUSH);
    assign lookup_ready = !busy;
    assign fsm_state    = state;
    assign accept       = lookup_valid && !busy;
    assign upd_ok       = upd_wren && !busy;
    assign bypass       = accept && upd_ok && (upd_idx == lookup_idx);

    always_comb begin
        upd_entry                 = '0;
        upd_entry[TAG_BITS-1:0]   = upd_tag;
        upd_entry[VALID_BIT]      = upd_valid;
`ifdef CACHE_TAG_DIRTY_EN
        upd_entry[TAG_BITS+1]     = upd_dirty;
`endif
    end

`ifndef CACHE_TAG_DIRTY_EN
    logic unused_upd_dirty;
    assign unused_upd_dirty = upd_dirty;
`endif

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_done  = 1'b0;
        ram_we     = upd_ok;
        ram_waddr  = upd_idx;
        ram_wdata  = upd_entry;
        case (state)
            ST_IDLE: begin
                if (flush_req) begin
                    next_state = ST_FLUSH;
                    next_cnt   = '0;
                end
            end
            ST_FLUSH: begin
                ram_we    = 1'b1;
                ram_waddr = cnt;
                ram_wdata = '0;
                next_cnt  = cnt + 1'b1;
                if (cnt == LAST_IDX) begin
                    next_state = ST_IDLE;
                    next_done  = 1'b1;
                end
            end
            default: next_state = ST_FLUSH;
        endcase
    end

    // Bypass register starts enabled with an all-zero entry so rsp_* read as zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_FLUSH;
            cnt         <= '0;
            flush_done  <= 1'b0;
            rsp_valid   <= 1'b0;
            tag_q       <= '0;
            byp_en_q    <= 1'b1;
            byp_entry_q <= '0;
        end else begin
            state      <= next_state;
            cnt        <= next_cnt;
            flush_done <= next_done;
            rsp_valid  <= accept;
            if (accept) begin
                tag_q       <= lookup_tag;
                byp_en_q    <= bypass;
                byp_entry_q <= upd_entry;
            end
        end
    end

    tag_ram_sp #(
        .WIDTH     (ENTRY_W),
        .ADDR_BITS (IDX_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (accept),
        .raddr (lookup_idx),
        .rdata (rd_entry)
    );

    assign stored  = byp_en_q ? byp_entry_q : rd_entry;
    assign rsp_tag = stored[TAG_BITS-1:0];
    assign rsp_hit = stored[VALID_BIT] && (stored[TAG_BITS-1:0] == tag_q);
`ifdef CACHE_TAG_DIRTY_EN
    assign rsp_dirty = stored[TAG_BITS+1];
`else
    assign rsp_dirty = 1'b0;
`endif

endmodule

// File: tb/tb_cache_tag_store.sv
// Directed bench for cache_tag_store (IDX_BITS=4) with a response scoreboard.
// Expected rsp_dirty follows CACHE_TAG_DIRTY_EN.
module tb_cache_tag_store;
    import cache_tag_store_pkg::*;

    localparam int IDX_BITS = 4;
    localparam int TAG_BITS = 8;
    localparam int SWEEP    = 16;
`ifdef CACHE_TAG_DIRTY_EN
    localparam logic DIRTY_ON = 1'b1;
`else
    localparam logic DIRTY_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                lookup_valid = 1'b0;
    logic                lookup_ready;
    logic [IDX_BITS-1:0] lookup_idx = '0;
    logic [TAG_BITS-1:0] lookup_tag = '0;
    logic                rsp_valid, rsp_hit, rsp_dirty;
    logic [TAG_BITS-1:0] rsp_tag;
    logic                upd_wren = 1'b0;
    logic [IDX_BITS-1:0] upd_idx = '0;
    logic [TAG_BITS-1:0] upd_tag = '0;
    logic                upd_valid = 1'b0;
    logic                upd_dirty = 1'b0;
    logic                flush_req = 1'b0;
    logic                busy, flush_done;
    state_t              fsm_state;

    int checks = 0;
    int errors = 0;
    logic [TAG_BITS+1:0] exp_q[$];

    cache_tag_store #(.IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS)) dut (
        .clk(clk), .reset_n(reset_n),
        .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
        .lookup_idx(lookup_idx), .lookup_tag(lookup_tag),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_dirty(rsp_dirty), .rsp_tag(rsp_tag),
        .upd_wren(upd_wren), .upd_idx(upd_idx), .upd_tag(upd_tag),
        .upd_valid(upd_valid), .upd_dirty(upd_dirty),
        .flush_req(flush_req), .busy(busy), .flush_done(flush_done), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got hit=%0b tag=%0h expected no response", rsp_hit, rsp_tag);
            end else begin
                logic [TAG_BITS+1:0] e;
                e = exp_q.pop_front();
                if ({rsp_hit, rsp_dirty, rsp_tag} !== e) begin
                    errors++;
                    $display("FAIL rsp: got hit=%0b dirty=%0b tag=%0h expected hit=%0b dirty=%0b tag=%0h",
                             rsp_hit, rsp_dirty, rsp_tag, e[TAG_BITS+1], e[TAG_BITS], e[TAG_BITS-1:0]);
                end
            end
        end
    end

    // drivers
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lookup(input logic [IDX_BITS-1:0] idx, input logic [TAG_BITS-1:0] tag,
                              input logic hit, input logic dirty, input logic [TAG_BITS-1:0] etag);
        check("lookup_ready", lookup_ready, 1);
        lookup_valid = 1'b1;
        lookup_idx   = idx;
        lookup_tag   = tag;
        exp_q.push_back({hit, dirty, etag});
    endtask

    task automatic set_update(input logic [IDX_BITS-1:0] idx, input logic [TAG_BITS-1:0] tag,
                              input logic valid, input logic dirty);
        upd_wren  = 1'b1;
        upd_idx   = idx;
        upd_tag   = tag;
        upd_valid = valid;
        upd_dirty = dirty;
    endtask

    task automatic lookup(input logic [IDX_BITS-1:0] idx, input logic [TAG_BITS-1:0] tag,
                          input logic hit, input logic dirty, input logic [TAG_BITS-1:0] etag);
        set_lookup(idx, tag, hit, dirty, etag);
        tick();
        lookup_valid = 1'b0;
    endtask

    task automatic update(input logic [IDX_BITS-1:0] idx, input logic [TAG_BITS-1:0] tag,
                          input logic valid, input logic dirty);
        set_update(idx, tag, valid, dirty);
        tick();
        upd_wren = 1'b0;
    endtask

    task automatic wait_flush(input string name);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        for (int g = 0; g < 100 && !done; g++) begin
            @(negedge clk);
            if (busy) n++;
            else done = 1'b1;
        end
        check({name, "_busy_cycles"}, n, SWEEP);
        check({name, "_done_pulse"}, flush_done, 1);
        @(negedge clk);
        check({name, "_done_clear"}, flush_done, 0);
    endtask

    initial begin
        int  n;
        bit  done;

        // reset state
        tick();
        tick();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_hit", rsp_hit, 0);
        check("rst_rsp_dirty", rsp_dirty, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_busy", busy, 1);
        check("rst_lookup_ready", lookup_ready, 0);
        check("rst_state", fsm_state, ST_FLUSH);
        reset_n = 1'b1;
        wait_flush("init");
        check("idle_state", fsm_state, ST_IDLE);
        lookup(5, 8'h00, 1'b0, 1'b0, 8'h00);

        // basic hit / miss, then back-to-back
        update(3, 8'hA5, 1'b1, 1'b0);
        set_lookup(3, 8'hA5, 1'b1, 1'b0, 8'hA5);
        tick();
        lookup(3, 8'hA4, 1'b0, 1'b0, 8'hA5);
        tick();
        @(negedge clk);
        check("hold_rsp_valid", rsp_valid, 0);
        check("hold_rsp_tag", rsp_tag, 8'hA5);
        check("hold_rsp_hit", rsp_hit, 0);

        // same-index bypass, and independent different-index update
        set_update(7, 8'h3C, 1'b1, 1'b0);
        lookup(7, 8'h3C, 1'b1, 1'b0, 8'h3C);
        upd_wren = 1'b0;
        set_update(8, 8'h55, 1'b1, 1'b0);
        lookup(3, 8'hA5, 1'b1, 1'b0, 8'hA5);
        upd_wren = 1'b0;
        lookup(8, 8'h55, 1'b1, 1'b0, 8'h55);
        lookup(7, 8'h3C, 1'b1, 1'b0, 8'h3C);

        // dirty bit, stored and bypassed; invalid entry with matching tag
        update(2, 8'h11, 1'b1, 1'b1);
        lookup(2, 8'h11, 1'b1, DIRTY_ON, 8'h11);
        set_update(10, 8'h42, 1'b1, 1'b1);
        lookup(10, 8'h42, 1'b1, DIRTY_ON, 8'h42);
        upd_wren = 1'b0;
        update(9, 8'h77, 1'b0, 1'b0);
        lookup(9, 8'h77, 1'b0, 1'b0, 8'h77);

        // fill, flush with a same-cycle lookup, activity while busy
        for (int i = 0; i < 16; i++) update(i[IDX_BITS-1:0], 8'h20 + i[7:0], 1'b1, 1'b0);
        flush_req = 1'b1;
        set_lookup(4, 8'h24, 1'b1, 1'b0, 8'h24);
        tick();
        flush_req = 1'b0;
        n    = 0;
        done = 1'b0;
        for (int g = 0; g < 100 && !done; g++) begin
            @(negedge clk);
            if (busy) begin
                n++;
                check("busy_lookup_ready", lookup_ready, 0);
                upd_wren  = (n == 3);
                upd_idx   = 0;
                upd_tag   = 8'h99;
                upd_valid = 1'b1;
                flush_req = (n == 6);
            end else begin
                done         = 1'b1;
                lookup_valid = 1'b0;
                upd_wren     = 1'b0;
                flush_req    = 1'b0;
            end
        end
        check("flush2_busy_cycles", n, SWEEP);
        check("flush2_done_pulse", flush_done, 1);
        for (int i = 0; i < 16; i++) lookup(i[IDX_BITS-1:0], 8'h20 + i[7:0], 1'b0, 1'b0, 8'h00);

        // update in the same cycle as flush_req is cleared by the sweep
        set_update(6, 8'h66, 1'b1, 1'b0);
        flush_req = 1'b1;
        tick();
        upd_wren  = 1'b0;
        flush_req = 1'b0;
        wait_flush("flush3");
        lookup(6, 8'h66, 1'b0, 1'b0, 8'h00);

        // reset mid-sweep restarts the sweep and clears outputs
        update(3, 8'h33, 1'b1, 1'b0);
        lookup(3, 8'h33, 1'b1, 1'b0, 8'h33);
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_rsp_tag", rsp_tag, 0);
        check("mid_rst_rsp_hit", rsp_hit, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_busy", busy, 1);
        tick();
        reset_n = 1'b1;
        wait_flush("rst_sweep");
        lookup(3, 8'h33, 1'b0, 1'b0, 8'h00);

        tick();
        tick();
        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
